// File: rtl/nvm_cmd_sequencer.sv
// nvm_cmd_sequencer: drives the byte-wide parallel-in/serial-out shifter of the
// NVM reader's transmit path. A request (opcode + address) is taken over a
// valid/ready handshake, then each byte is loaded and shifted out MSB first
// inside a chip-select frame, followed by optional dummy cycles and a done
// pulse. A synchronous abort cancels a transfer in progress.
module nvm_cmd_sequencer #(
  parameter int ADDR_BYTES   = 3,  // 1..4
  parameter int DUMMY_CYCLES = 0   // 0..255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_opcode,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic                    abort,
  output logic                    piso_load,
  output logic                    piso_shift,
  output logic [7:0]              piso_data,
  output logic                    bit_valid,
  output logic                    cs_n,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  // Opcode followed by the address bytes, opcode in the top byte so the
  // byte to load next is always the top byte of the buffer.
  localparam int        BUF_W      = 8 * (ADDR_BYTES + 1);
  localparam logic [2:0] LAST_IDX  = 3'(ADDR_BYTES);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam bit        HAS_DUMMY  = (DUMMY_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    TAIL,
    DUMMY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   byte_buf_q, byte_buf_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         dummy_cnt_q, dummy_cnt_d;
  logic               abort_take;

  logic               req_ready_q, req_ready_d;
  logic               piso_load_q, piso_load_d;
  logic               piso_shift_q, piso_shift_d;
  logic [7:0]         piso_data_q, piso_data_d;
  logic               bit_valid_q, bit_valid_d;
  logic               cs_n_q, cs_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  // Next-state logic: sequencing through load/shift per byte, tail, dummy, done.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    byte_buf_d  = byte_buf_q;
    byte_idx_d  = byte_idx_q;
    bit_cnt_d   = bit_cnt_q;
    dummy_cnt_d = dummy_cnt_q;

    // Abort only cancels a live transfer; in IDLE or DONE it is ignored.
    abort_take = abort && (state_q != IDLE) && (state_q != DONE);

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          byte_buf_d = {req_opcode, req_addr};
          byte_idx_d = 3'd0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_d = 3'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_idx_q < LAST_IDX) begin
            byte_idx_d = byte_idx_q + 3'd1;
            byte_buf_d = {byte_buf_q[BUF_W-9:0], 8'h00};
            state_d    = LOAD;
          end else begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        dummy_cnt_d = 8'd0;
        state_d     = HAS_DUMMY ? DUMMY : DONE;
      end
      DUMMY: begin
        if (dummy_cnt_q == DUMMY_LAST) begin
          state_d = DONE;
        end else begin
          dummy_cnt_d = dummy_cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other transition and drops the buffered request.
    if (abort_take) begin
      state_d    = IDLE;
      byte_buf_d = '0;
    end
  end

  // Output values for the coming cycle, decoded from the next state so the
  // outputs can be registered without adding a cycle of latency.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    cs_n_d       = (state_d == IDLE) || (state_d == DONE);
    piso_load_d  = (state_d == LOAD);
    piso_shift_d = (state_d == SHIFT);
    piso_data_d  = piso_load_d ? byte_buf_d[BUF_W-1 -: 8] : 8'h00;
    // The shifter presents a bit the cycle after each shift strobe.
    bit_valid_d  = piso_shift_q && !abort_take;
    done_d       = (state_d == DONE);
    aborted_d    = abort_take;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the byte buffer is only a few bytes of flops, so it is reset with
      // everything else rather than left as an unreset storage array.
      state_q      <= IDLE;
      byte_buf_q   <= '0;
      byte_idx_q   <= 3'd0;
      bit_cnt_q    <= 3'd0;
      dummy_cnt_q  <= 8'd0;
      req_ready_q  <= 1'b1;
      piso_load_q  <= 1'b0;
      piso_shift_q <= 1'b0;
      piso_data_q  <= 8'h00;
      bit_valid_q  <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      state_q      <= state_d;
      byte_buf_q   <= byte_buf_d;
      byte_idx_q   <= byte_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      dummy_cnt_q  <= dummy_cnt_d;
      req_ready_q  <= req_ready_d;
      piso_load_q  <= piso_load_d;
      piso_shift_q <= piso_shift_d;
      piso_data_q  <= piso_data_d;
      bit_valid_q  <= bit_valid_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign piso_load  = piso_load_q;
  assign piso_shift = piso_shift_q;
  assign piso_data  = piso_data_q;
  assign bit_valid  = bit_valid_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_nvm_cmd_sequencer.sv
// Testbench for nvm_cmd_sequencer. Three instances cover the default
// configuration, eight dummy cycles, and a single address byte. A timeline
// model derives every output from the cycle offset since accept; a bench-side
// shifter reassembles the serial stream and compares it to the request.
module tb_nvm_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rv       [3];
  logic        abort_in [3];
  logic [7:0]  op_in    [3];
  logic [31:0] addr_in  [3];

  logic        req_ready_w  [3];
  logic        piso_load_w  [3];
  logic        piso_shift_w [3];
  logic [7:0]  piso_data_w  [3];
  logic        bit_valid_w  [3];
  logic        cs_n_w       [3];
  logic        busy_w       [3];
  logic        done_w       [3];
  logic        aborted_w    [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic int ab_of(input int d);
    return (d == 2) ? 1 : 3;
  endfunction

  function automatic int dc_of(input int d);
    return (d == 1) ? 8 : 0;
  endfunction

  // Offset of the done cycle relative to the accept edge.
  function automatic int len_of(input int d);
    return 9 * (ab_of(d) + 1) + 2 + dc_of(d);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GAB = (g == 2) ? 1 : 3;
    localparam int GDC = (g == 1) ? 8 : 0;
    nvm_cmd_sequencer #(
      .ADDR_BYTES  (GAB),
      .DUMMY_CYCLES(GDC)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (rv[g]),
      .req_ready (req_ready_w[g]),
      .req_opcode(op_in[g]),
      .req_addr  (addr_in[g][8*GAB-1:0]),
      .abort     (abort_in[g]),
      .piso_load (piso_load_w[g]),
      .piso_shift(piso_shift_w[g]),
      .piso_data (piso_data_w[g]),
      .bit_valid (bit_valid_w[g]),
      .cs_n      (cs_n_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .aborted   (aborted_w[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per instance, the cycle offset since the accept edge
  // (0 = idle) plus the captured request, left-aligned in 40 bits.
  // ---------------------------------------------------------------------------
  int          m_off [3] = '{0, 0, 0};
  logic        m_abp [3] = '{1'b0, 1'b0, 1'b0};
  logic [39:0] m_pay [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_off[d] <= 0;
        m_abp[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_abp[d] <= 1'b0;
        if (m_off[d] == 0) begin
          if (rv[d]) begin
            m_off[d] <= 1;
            m_pay[d] <= {op_in[d], addr_in[d] << (8 * (4 - ab_of(d)))};
          end
        end else if (m_off[d] == len_of(d)) begin
          m_off[d] <= 0;
        end else if (abort_in[d]) begin
          m_off[d] <= 0;
          m_abp[d] <= 1'b1;
        end else begin
          m_off[d] <= m_off[d] + 1;
        end
      end
    end
  end

  // Bench-side shifter and collector of bit_valid-qualified serial bits.
  logic [7:0]  sh_reg [3];
  logic        sout   [3] = '{1'b0, 1'b0, 1'b0};
  logic [39:0] s_data [3];
  int          s_bits [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (piso_load_w[d]) begin
        sh_reg[d] <= piso_data_w[d];
        sout[d]   <= 1'b0;
      end else if (piso_shift_w[d]) begin
        sout[d]   <= sh_reg[d][7];
        sh_reg[d] <= {sh_reg[d][6:0], 1'b0};
      end else begin
        sout[d] <= 1'b0;
      end
      if (m_off[d] == 1) begin
        s_data[d] <= '0;
        s_bits[d] <= 0;
      end else if (bit_valid_w[d]) begin
        s_data[d] <= {s_data[d][38:0], sout[d]};
        s_bits[d] <= s_bits[d] + 1;
      end
    end
  end

  // Compare every output of every instance against the model each cycle.
  always @(negedge clk) begin
    int n, l, o, k;
    logic e_ready, e_csn, e_busy, e_ld, e_sh, e_bv, e_done;
    logic [7:0] e_data;
    for (int d = 0; d < 3; d++) begin
      n = ab_of(d) + 1;
      l = len_of(d);
      o = m_off[d];
      e_ready = 1'b1; e_csn = 1'b1; e_busy = 1'b0; e_ld = 1'b0;
      e_sh = 1'b0; e_bv = 1'b0; e_done = 1'b0; e_data = 8'h00;
      if (o > 0) begin
        e_ready = 1'b0;
        e_busy  = 1'b1;
        e_csn   = (o == l);
        e_done  = (o == l);
        if (o <= 9 * n) begin
          k = (o - 1) / 9;
          if ((o - 1) % 9 == 0) begin
            e_ld   = 1'b1;
            e_data = m_pay[d][39 - 8*k -: 8];
          end else begin
            e_sh = 1'b1;
          end
        end
        e_bv = (o >= 3) && (o <= 9 * n + 1) && ((o - 3) % 9 < 8);
      end
      check("req_ready",  d, req_ready_w[d],  e_ready);
      check("cs_n",       d, cs_n_w[d],       e_csn);
      check("busy",       d, busy_w[d],       e_busy);
      check("piso_load",  d, piso_load_w[d],  e_ld);
      check("piso_shift", d, piso_shift_w[d], e_sh);
      check("piso_data",  d, piso_data_w[d],  e_data);
      check("bit_valid",  d, bit_valid_w[d],  e_bv);
      check("done",       d, done_w[d],       e_done);
      check("aborted",    d, aborted_w[d],    m_abp[d]);
      if (o == l) begin
        check("stream_len",  d, s_bits[d], 8 * n);
        check("stream_bits", d, s_data[d], m_pay[d] >> (40 - 8 * n));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios with literal expectations
  // ---------------------------------------------------------------------------
  task automatic check_reset_vals(input int d);
    check("rst_req_ready",  d, req_ready_w[d],  1);
    check("rst_cs_n",       d, cs_n_w[d],       1);
    check("rst_piso_load",  d, piso_load_w[d],  0);
    check("rst_piso_shift", d, piso_shift_w[d], 0);
    check("rst_piso_data",  d, piso_data_w[d],  0);
    check("rst_bit_valid",  d, bit_valid_w[d],  0);
    check("rst_busy",       d, busy_w[d],       0);
    check("rst_done",       d, done_w[d],       0);
    check("rst_aborted",    d, aborted_w[d],    0);
  endtask

  // Entered just after the negedge of cycle 1; returns the done cycle number
  // and how many cycles cs_n was low from cycle 1 up to and including done.
  task automatic wait_done(input int d, output int lat, output int cs_low);
    bit got;
    got    = 1'b0;
    lat    = 1;
    cs_low = 0;
    while (!got && lat < 300) begin
      #1;
      if (cs_n_w[d] === 1'b0) cs_low++;
      if (done_w[d] === 1'b1) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, lat);
    end
  endtask

  task automatic directed(input int d, input logic [7:0] op, input logic [31:0] addr,
                          input int exp_done, input int exp_cs_low,
                          input logic [39:0] exp_stream, input int exp_bits);
    int lat, csl;
    @(negedge clk);
    op_in[d]   = op;
    addr_in[d] = addr;
    rv[d]      = 1'b1;
    #1 check("ready_at_accept", d, req_ready_w[d], 1);
    @(negedge clk);
    rv[d] = 1'b0;
    wait_done(d, lat, csl);
    check("done_cycle",    d, lat,            exp_done);
    check("cs_low_cycles", d, csl,            exp_cs_low);
    check("serial_count",  d, s_bits[d],      exp_bits);
    check("serial_stream", d, s_data[d],      exp_stream);
    check("ready_at_done", d, req_ready_w[d], 0);
    @(negedge clk);
    #1 check("ready_after_done", d, req_ready_w[d], 1);
  endtask

  task automatic abort_scenario();
    int lat, csl;
    @(negedge clk);                       // cycle 0
    op_in[0] = 8'h03; addr_in[0] = 32'h0012_3456; rv[0] = 1'b1;
    @(negedge clk);                       // cycle 1
    rv[0] = 1'b0;
    repeat (13) @(negedge clk);           // cycle 14
    abort_in[0] = 1'b1;
    #1 check("abort_mid_shift", 0, piso_shift_w[0], 1);
    @(negedge clk);                       // cycle 15
    abort_in[0] = 1'b0;
    #1;
    check("abort_cs_n",      0, cs_n_w[0],      1);
    check("abort_pulse",     0, aborted_w[0],   1);
    check("abort_done",      0, done_w[0],      0);
    check("abort_bit_valid", 0, bit_valid_w[0], 0);
    check("abort_ready",     0, req_ready_w[0], 1);
    op_in[0] = 8'h9F; addr_in[0] = 32'h00C0_FFEE; rv[0] = 1'b1;
    @(negedge clk);
    rv[0] = 1'b0;
    wait_done(0, lat, csl);
    check("post_abort_done",   0, lat,       38);
    check("post_abort_stream", 0, s_data[0], 40'h009F_C0FF_EE);
    @(negedge clk);
  endtask

  task automatic back_to_back();
    int t, dones, accepts, last_done;
    bit flip;
    t = 0; dones = 0; accepts = 0; last_done = -1; flip = 1'b0;
    @(negedge clk);
    op_in[0] = 8'h0B; addr_in[0] = 32'h0011_1111; rv[0] = 1'b1;
    while (dones < 3 && t < 400) begin
      #1;
      if (req_ready_w[0]) begin
        accepts++;
        flip = 1'b1;
        if (last_done >= 0) check("b2b_accept_gap", 0, t - last_done, 1);
      end
      if (done_w[0]) begin
        dones++;
        last_done = t;
        if (dones == 3) rv[0] = 1'b0;
      end
      @(negedge clk);
      t++;
      if (flip) begin
        flip = 1'b0;
        if (op_in[0] == 8'h0B) begin
          op_in[0] = 8'hEB; addr_in[0] = 32'h00EE_EEEE;
        end else begin
          op_in[0] = 8'h0B; addr_in[0] = 32'h0011_1111;
        end
      end
    end
    check("b2b_dones",   0, dones,   3);
    check("b2b_accepts", 0, accepts, 3);
    rv[0] = 1'b0;
  endtask

  task automatic reset_scenario();
    @(negedge clk);                       // cycle 0 for all instances
    for (int d = 0; d < 3; d++) begin
      op_in[d] = 8'h5A; addr_in[d] = 32'h0A0B_0C0D; rv[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rv[d] = 1'b0;
    repeat (19) @(negedge clk);           // cycle 20
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_reset_vals(d);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; abort_in[d] = 1'b0; op_in[d] = 8'h00; addr_in[d] = 32'h0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check_reset_vals(d);

    directed(0, 8'h03, 32'h0012_3456, 38, 37, 40'h00_0312_3456, 32);
    directed(1, 8'h03, 32'h0012_3456, 46, 45, 40'h00_0312_3456, 32);
    directed(2, 8'hA5, 32'h0000_00FF, 20, 19, 40'h00_0000_A5FF, 16);
    abort_scenario();
    back_to_back();
    @(negedge clk);
    reset_scenario();
    directed(2, 8'hA5, 32'h0000_00FF, 20, 19, 40'h00_0000_A5FF, 16);
    directed(0, 8'h03, 32'h0012_3456, 38, 37, 40'h00_0312_3456, 32);

    // Randomized traffic: independent requests, payloads and rare aborts.
    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        rv[d]       = 1'($urandom_range(0, 1));
        op_in[d]    = 8'($urandom);
        addr_in[d]  = $urandom;
        abort_in[d] = ($urandom_range(0, 63) == 0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; abort_in[d] = 1'b0;
    end
    repeat (80) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
